// File: rtl/uart_pkg.sv
// Shared types and constants for the transmit arbiter.
package uart_pkg;

   // Data byte width presented to the transmitter.
   localparam int DATA_W = 8;

   // Width of the SEND-phase timeout counter.
   localparam int CNT_W = 8;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic winner,
   output logic any
);

   // Select the winner index and flag whether anyone is requesting.
   always_comb begin
      any    = valid0 | valid1;
      winner = valid1;
      if (valid0 && valid1) begin
         winner = ~last_grant;
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Two-requester byte arbiter in front of a single transmitter.
//
// Handshake: a requester byte is transferred on the rising clk edge where
// REQx_VALID and REQx_READY are both high. READY is only offered in IDLE,
// while the transmitter reports idle, and only to the picked requester, so at
// most one READY is high per cycle. After the handshake, VALID/DATA are
// ignored until the FSM is back in IDLE. TX_EN is a level held through SEND;
// the transmitter acknowledges by dropping TX_STATUS, after which the arbiter
// waits in DRAIN for TX_STATUS to return high.
module tx_arbiter
   import uart_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              REQ0_VALID,
   input  logic              REQ1_VALID,
   input  logic [DATA_W-1:0] REQ0_DATA,
   input  logic [DATA_W-1:0] REQ1_DATA,
   output logic              REQ0_READY,
   output logic              REQ1_READY,
   input  logic              TX_STATUS,
   output logic              TX_EN,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              GRANT,
   output logic              TX_ERR,
   output arb_state_t        state_dbg
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [CNT_W-1:0]  counter;
   logic              last_grant;
   logic              pick_winner;
   logic              pick_any;
   logic              handshake;
   logic              timeout_hit;
   logic [DATA_W-1:0] win_data;

   rr_pick2 u_pick (
      .valid0     (REQ0_VALID),
      .valid1     (REQ1_VALID),
      .last_grant (last_grant),
      .winner     (pick_winner),
      .any        (pick_any)
   );

   assign win_data  = pick_winner ? REQ1_DATA : REQ0_DATA;
   assign state_dbg = state;

   // Next-state logic plus the combinational READY/TX_EN outputs.
   always_comb begin
      state_nxt   = state;
      handshake   = 1'b0;
      timeout_hit = 1'b0;
      REQ0_READY  = 1'b0;
      REQ1_READY  = 1'b0;
      TX_EN       = 1'b0;
      case (state)
         IDLE: begin
            // Reset is gated in so READY stays low for the whole reset pulse.
            if (TX_STATUS && pick_any && !reset) begin
               handshake  = 1'b1;
               REQ0_READY = ~pick_winner;
               REQ1_READY = pick_winner;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            TX_EN = 1'b1;
            if (!TX_STATUS) begin
               state_nxt = DRAIN;
            end else if (counter == TIMEOUT_C) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         DRAIN: begin
            if (TX_STATUS) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Transfer datapath: captured byte, grant history, timeout counter, error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         TX_DATA    <= '0;
         GRANT      <= 1'b0;
         last_grant <= 1'b1;
         counter    <= '0;
         TX_ERR     <= 1'b0;
      end else begin
         TX_ERR <= timeout_hit;
         if (handshake) begin
            TX_DATA    <= win_data;
            GRANT      <= pick_winner;
            last_grant <= pick_winner;
            counter    <= '0;
         end else if (state == SEND && counter != CNT_MAX) begin
            counter <= counter + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a frame scoreboard and a transmitter model.
module tb_tx_arbiter;
   import uart_pkg::*;

   // Clock and reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       tx_status;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       grant;
   logic       tx_err;
   arb_state_t state_dbg;

   // Transmitter status: either manual level or the auto model.
   logic auto_tx;
   logic tx_man;
   logic model_status;
   int   model_lat;
   int   model_busy;
   assign tx_status = auto_tx ? model_status : tx_man;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   int starts = 0;
   int ends = 0;
   int last_len = 0;
   int cur_len = 0;
   int err_cycles = 0;

   tx_arbiter #(.TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .REQ0_VALID (req0_valid),
      .REQ1_VALID (req1_valid),
      .REQ0_DATA  (req0_data),
      .REQ1_DATA  (req1_data),
      .REQ0_READY (req0_ready),
      .REQ1_READY (req1_ready),
      .TX_STATUS  (tx_status),
      .TX_EN      (tx_en),
      .TX_DATA    (tx_data),
      .GRANT      (grant),
      .TX_ERR     (tx_err),
      .state_dbg  (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Transmitter model: drops status model_lat cycles into SEND, stays busy model_busy cycles.
   initial begin : tx_model
      int  cnt;
      int  bcnt;
      bit  busy;
      model_status = 1'b1;
      cnt = 0;
      bcnt = 0;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!auto_tx) begin
            cnt = 0;
            bcnt = 0;
            busy = 1'b0;
            model_status = 1'b1;
         end else if (busy) begin
            bcnt++;
            if (bcnt >= model_busy) begin
               model_status = 1'b1;
               busy = 1'b0;
               cnt = 0;
            end
         end else if (tx_en) begin
            cnt++;
            if (cnt >= model_lat) begin
               model_status = 1'b0;
               busy = 1'b1;
               bcnt = 0;
            end
         end
      end
   end

   // Monitor: scoreboard compare at each frame start, frame length and error tracking.
   initial begin : monitor
      logic       prev_en;
      logic [8:0] e;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_err === 1'b1) err_cycles++;
         if (tx_en === 1'b1 && !prev_en) begin
            starts++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame actual=%0h expected=none", {grant, tx_data});
            end else begin
               e = exp_q.pop_front();
               check("frame_grant_data", {23'd0, grant, tx_data}, {23'd0, e});
            end
         end
         if (tx_en === 1'b1) begin
            cur_len++;
         end else if (prev_en) begin
            last_len = cur_len;
            cur_len = 0;
            ends++;
         end
         prev_en = (tx_en === 1'b1);
      end
   end

   // Watchdog
   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin : main
      int s;
      int e0;
      int n;
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_data = 8'h00;
      req1_data = 8'h00;
      auto_tx = 1'b0;
      tx_man = 1'b1;
      model_lat = 1;
      model_busy = 10;

      // Reset state, READY held low even with VALID and idle transmitter
      tick();
      tick();
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      check("rst_tx_en", 32'(tx_en), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_tx_err", 32'(tx_err), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      req0_valid = 1'b0;
      reset = 1'b0;
      tick();

      // Single requester 0, byte A5
      req0_valid = 1'b1;
      req0_data = 8'hA5;
      exp_q.push_back({1'b0, 8'hA5});
      #1;
      check("t1_ready0", 32'(req0_ready), 32'd1);
      check("t1_ready1", 32'(req1_ready), 32'd0);
      tick();
      check("t1_ready0_after", 32'(req0_ready), 32'd0);
      check("t1_tx_en", 32'(tx_en), 32'd1);
      check("t1_tx_data", 32'(tx_data), 32'hA5);
      check("t1_grant", 32'(grant), 32'd0);
      req0_data = 8'hFF;
      tx_man = 1'b0;
      tick();
      check("t1_drain_state", 32'(state_dbg), 32'(DRAIN));
      check("t1_drain_tx_en", 32'(tx_en), 32'd0);
      check("t1_data_stable", 32'(tx_data), 32'hA5);
      req0_valid = 1'b0;
      tx_man = 1'b1;
      tick();
      check("t1_idle", 32'(state_dbg), 32'(IDLE));

      // Transmitter busy in IDLE blocks READY; release grants requester 1 same cycle
      tx_man = 1'b0;
      req1_valid = 1'b1;
      req1_data = 8'h5C;
      #1;
      check("t2_blocked_ready1", 32'(req1_ready), 32'd0);
      tick();
      tick();
      tick();
      check("t2_blocked_ready1_later", 32'(req1_ready), 32'd0);
      check("t2_blocked_state", 32'(state_dbg), 32'(IDLE));
      exp_q.push_back({1'b1, 8'h5C});
      tx_man = 1'b1;
      #1;
      check("t2_release_ready1", 32'(req1_ready), 32'd1);
      check("t2_release_ready0", 32'(req0_ready), 32'd0);
      tick();
      check("t2_grant", 32'(grant), 32'd1);
      check("t2_tx_data", 32'(tx_data), 32'h5C);
      req1_valid = 1'b0;
      tx_man = 1'b0;
      tick();
      tx_man = 1'b1;
      tick();
      check("t2_idle", 32'(state_dbg), 32'(IDLE));

      // VALID withdrawn before a grant produces no transfer
      s = starts;
      tx_man = 1'b0;
      req0_valid = 1'b1;
      req0_data = 8'h42;
      tick();
      req0_valid = 1'b0;
      tick();
      tx_man = 1'b1;
      #1;
      check("t3_no_ready0", 32'(req0_ready), 32'd0);
      tick();
      tick();
      tick();
      check("t3_no_frame", 32'(starts - s), 32'd0);

      // Both requesters continuously valid, transmitter busy 10 cycles per byte
      s = starts;
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b1, 8'h22});
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b1, 8'h22});
      model_lat = 1;
      model_busy = 10;
      auto_tx = 1'b1;
      req0_data = 8'h11;
      req1_data = 8'h22;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (n = 0; n < 200; n++) begin
         tick();
         if (starts >= s + 4) break;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("t4_four_frames", 32'(starts - s), 32'd4);
      for (n = 0; n < 100; n++) begin
         tick();
         if (state_dbg == IDLE) break;
      end
      check("t4_back_idle", 32'(state_dbg), 32'(IDLE));
      tick();
      tick();
      auto_tx = 1'b0;
      tx_man = 1'b1;
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t4_no_err", 32'(err_cycles), 32'd0);

      // Slow transmitter: status falls 40 cycles after TX_EN
      s = starts;
      e0 = err_cycles;
      model_lat = 40;
      model_busy = 3;
      auto_tx = 1'b1;
      exp_q.push_back({1'b0, 8'h3C});
      req0_data = 8'h3C;
      req0_valid = 1'b1;
      #1;
      check("t5_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      for (n = 0; n < 120; n++) begin
         tick();
         if (state_dbg == IDLE) break;
      end
      check("t5_len", 32'(last_len), 32'd40);
      check("t5_no_err", 32'(err_cycles - e0), 32'd0);
      check("t5_sent_once", 32'(starts - s), 32'd1);
      auto_tx = 1'b0;
      tx_man = 1'b1;
      tick();

      // Transmitter never acknowledges: timeout after 256 SEND cycles
      e0 = err_cycles;
      exp_q.push_back({1'b1, 8'h77});
      req1_data = 8'h77;
      req1_valid = 1'b1;
      #1;
      check("t6_ready1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      check("t6_tx_en", 32'(tx_en), 32'd1);
      for (n = 0; n < 300; n++) begin
         tick();
         if (tx_en !== 1'b1) break;
      end
      check("t6_len", 32'(last_len), 32'd256);
      check("t6_tx_err_pulse", 32'(tx_err), 32'd1);
      check("t6_state_idle", 32'(state_dbg), 32'(IDLE));
      tick();
      check("t6_tx_err_clear", 32'(tx_err), 32'd0);
      check("t6_err_once", 32'(err_cycles - e0), 32'd1);

      // Reset during DRAIN, then tie goes to requester 0
      exp_q.push_back({1'b0, 8'h99});
      req0_data = 8'h99;
      req0_valid = 1'b1;
      #1;
      check("t7_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tx_man = 1'b0;
      tick();
      check("t7_in_drain", 32'(state_dbg), 32'(DRAIN));
      e0 = err_cycles;
      reset = 1'b1;
      #1;
      check("t7_rst_tx_en", 32'(tx_en), 32'd0);
      check("t7_rst_tx_data", 32'(tx_data), 32'h00);
      check("t7_rst_grant", 32'(grant), 32'd0);
      check("t7_rst_state", 32'(state_dbg), 32'(IDLE));
      tick();
      reset = 1'b0;
      tx_man = 1'b1;
      req0_data = 8'hAA;
      req1_data = 8'hBB;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      exp_q.push_back({1'b0, 8'hAA});
      #1;
      check("t7_tie_ready0", 32'(req0_ready), 32'd1);
      check("t7_tie_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("t7_tx_data", 32'(tx_data), 32'hAA);
      check("t7_grant", 32'(grant), 32'd0);
      tx_man = 1'b0;
      tick();
      tx_man = 1'b1;
      tick();
      tick();
      check("t7_no_err", 32'(err_cycles - e0), 32'd0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
